// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int COUNT_W   = $clog2(DIV_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract M, keep or restore.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] trial_s;
    logic             trial_neg_s;

    // Trial subtraction is one bit wider than A so its sign bit is the borrow.
    always_comb begin
        shifted_s   = {a, q[WIDTH-1]};
        trial_s     = shifted_s - {2'b00, m};
        trial_neg_s = trial_s[WIDTH+1];
        if (trial_neg_s) begin
            a_next = shifted_s[WIDTH:0];
            q_next = {q[WIDTH-2:0], 1'b0};
        end else begin
            a_next = trial_s[WIDTH:0];
            q_next = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Start/busy/done sequencer retiring one quotient bit per clock; result Z = {remainder, quotient}.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   RegA,
    input  logic [WIDTH-1:0]   RegB,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic [2*WIDTH-1:0] Z
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_r;
    div_state_e       state_next_s;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH:0]   a_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] m_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [WIDTH:0]   a_step_s;
    logic [WIDTH-1:0] q_step_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic             last_iter_s;
    logic             divisor_zero_s;

    // Magnitude of 0x80..0 is itself when read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (SIGNED && v[WIDTH-1]) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_r),
        .q      (q_r),
        .m      (m_r),
        .a_next (a_step_s),
        .q_next (q_step_s)
    );

    // Next-state decode and sign fix-up of the finished remainder/quotient.
    always_comb begin
        state_next_s   = state_r;
        last_iter_s    = (count_r == CNT_W'(WIDTH - 1));
        divisor_zero_s = (divisor_r == {WIDTH{1'b0}});
        rem_fix_s      = neg_r_r ? -a_r[WIDTH-1:0] : a_r[WIDTH-1:0];
        quo_fix_s      = neg_q_r ? -q_r : q_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_PREP;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_PREP: begin
                if (divisor_zero_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_ITER;
                end
            end
            S_ITER: begin
                if (last_iter_s) begin
                    state_next_s = S_FIX;
                end else begin
                    state_next_s = S_ITER;
                end
            end
            S_FIX:   state_next_s = S_DONE;
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s == S_PREP) || (state_next_s == S_ITER) ||
                       (state_next_s == S_FIX);
            done    <= (state_next_s == S_DONE);
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r    <= {CNT_W{1'b0}};
            dividend_r <= {WIDTH{1'b0}};
            divisor_r  <= {WIDTH{1'b0}};
            a_r        <= {(WIDTH+1){1'b0}};
            q_r        <= {WIDTH{1'b0}};
            m_r        <= {WIDTH{1'b0}};
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div_zero   <= 1'b0;
            Z          <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        dividend_r <= RegA;
                        divisor_r  <= RegB;
                        div_zero   <= 1'b0;
                    end
                end
                S_PREP: begin
                    if (divisor_zero_s) begin
                        div_zero <= 1'b1;
                        Z        <= {dividend_r, {WIDTH{1'b1}}};
                    end else begin
                        q_r     <= magnitude(dividend_r);
                        m_r     <= magnitude(divisor_r);
                        a_r     <= {(WIDTH+1){1'b0}};
                        neg_q_r <= SIGNED & (dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1]);
                        neg_r_r <= SIGNED & dividend_r[WIDTH-1];
                        count_r <= {CNT_W{1'b0}};
                    end
                end
                S_ITER: begin
                    a_r     <= a_step_s;
                    q_r     <= q_step_s;
                    count_r <= count_r + CNT_W'(1);
                end
                S_FIX: begin
                    Z <= {rem_fix_s, quo_fix_s};
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized and directed bench for div_seq_ctrl; signed and unsigned instances share stimulus.
module tb_div_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] RegA  = 32'd0;
    logic [31:0] RegB  = 32'd0;
    logic        busy_s, done_s, dz_s;
    logic        busy_u, done_u, dz_u;
    logic [63:0] z_s, z_u;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    div_seq_ctrl #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
        .clock(clock), .reset(reset), .start(start), .RegA(RegA), .RegB(RegB),
        .busy(busy_s), .done(done_s), .div_zero(dz_s), .Z(z_s)
    );

    div_seq_ctrl #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
        .clock(clock), .reset(reset), .start(start), .RegA(RegA), .RegB(RegB),
        .busy(busy_u), .done(done_u), .div_zero(dz_u), .Z(z_u)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference divide from plain integer arithmetic (truncating /, dividend-signed %).
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint na, nb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            na = longint'(signed'(a));
            nb = longint'(signed'(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q  = na / nb;
        r  = na % nb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Transaction-level model: cycles remaining until done, plus held results.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_zs = 64'd0, m_zu = 64'd0, p_zs = 64'd0, p_zu = 64'd0;
    bit          m_dz = 1'b0, p_dz = 1'b0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_zs   <= 64'd0;
            m_zu   <= 64'd0;
            m_dz   <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_zs   <= p_zs;
                m_zu   <= p_zu;
                m_dz   <= p_dz;
            end
        end else if (start) begin
            m_left <= (RegB == 32'd0) ? 1 : 34;
            p_zs   <= ref_div(RegA, RegB, 1'b1);
            p_zu   <= ref_div(RegA, RegB, 1'b0);
            p_dz   <= (RegB == 32'd0);
            m_dz   <= 1'b0;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("busy_s", {63'd0, busy_s}, {63'd0, (m_left > 0)});
            check("done_s", {63'd0, done_s}, {63'd0, m_done});
            check("dz_s",   {63'd0, dz_s},   {63'd0, m_dz});
            check("z_s",    z_s,             m_zs);
            check("busy_u", {63'd0, busy_u}, {63'd0, (m_left > 0)});
            check("done_u", {63'd0, done_u}, {63'd0, m_done});
            check("dz_u",   {63'd0, dz_u},   {63'd0, m_dz});
            check("z_u",    z_u,             m_zu);
        end
    end

    // One isolated divide with literal result, latency and busy-length checks.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit use_u,
                          input logic [63:0] lit_z, input bit lit_dz, input int lat);
        int n, nbusy;
        @(negedge clock);
        start = 1'b1; RegA = a; RegB = b;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        nbusy = busy_s ? 1 : 0;
        while (!done_s && n < 100) begin
            @(negedge clock);
            n++;
            if (busy_s) nbusy++;
        end
        check("latency", 64'(n), 64'(lat));
        check("busy_len", 64'(nbusy), 64'(lat - 1));
        check("lit_z", use_u ? z_u : z_s, lit_z);
        check("lit_dz", {63'd0, use_u ? dz_u : dz_s}, {63'd0, lit_dz});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'(32'($urandom_range(1, 20)));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int t_prev, n_done, w;
        repeat (2) @(posedge clock);
        chk_en = 1'b1;
        @(negedge clock);
        check("rst_busy", {63'd0, busy_s}, 64'd0);
        check("rst_done", {63'd0, done_s}, 64'd0);
        check("rst_dz",   {63'd0, dz_s},   64'd0);
        check("rst_z",    z_s,             64'd0);
        reset = 1'b0;

        do_div(32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 1'b0, 35);
        do_div(32'hFFFF_FF9C,  32'd7,          1'b0, 64'hFFFFFFFE_FFFFFFF2, 1'b0, 35);
        do_div(32'd100,        32'hFFFF_FFF9,  1'b0, 64'h00000002_FFFFFFF2, 1'b0, 35);
        do_div(32'd5,          32'd0,          1'b0, 64'h00000005_FFFFFFFF, 1'b1, 2);
        do_div(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 64'h00000000_80000000, 1'b0, 35);
        do_div(32'hFFFF_FFFF,  32'h10,         1'b1, 64'h0000000F_0FFFFFFF, 1'b0, 35);

        // Abort 1000/3 with reset mid-iteration after an ignored extra start.
        @(negedge clock);
        start = 1'b1; RegA = 32'd1000; RegB = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        start = 1'b1; RegA = 32'd77; RegB = 32'd0;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", {63'd0, busy_s}, 64'd0);
        check("abort_done", {63'd0, done_s}, 64'd0);
        check("abort_z",    z_s,             64'd0);
        reset = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clock);
            if (done_s) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        do_div(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 1'b0, 35);

        // Back-to-back with start held high.
        @(negedge clock);
        start = 1'b1;
        t_prev = -1;
        n_done = 0;
        repeat (150) begin
            RegA = $urandom;
            RegB = 32'($urandom_range(1, 1000));
            @(negedge clock);
            if (done_s) begin
                if (t_prev >= 0) check("b2b_period", 64'(cyc - t_prev), 64'd36);
                t_prev = cyc;
                n_done++;
            end
        end
        check("b2b_count", 64'(n_done >= 3), 64'd1);
        start = 1'b0;
        w = 0;
        while ((busy_s || done_s) && w < 100) begin
            @(negedge clock);
            w++;
        end
        check("b2b_drain", 64'(w < 100), 64'd1);

        // Randomized traffic, including starts while busy and occasional resets.
        repeat (2500) begin
            @(negedge clock);
            start = ($urandom_range(0, 2) == 0);
            RegA  = pick_operand();
            RegB  = pick_operand();
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
